// File: rtl/lightspeed_field.sv
// lightspeed_field: warp-effect streak field for the sprite renderer.
// Streaks fall per animation frame and respawn at LFSR-chosen columns.
module lightspeed_field #(
   parameter int          N_STREAKS = 4,
   parameter int          H_SIZE    = 2,
   parameter int          S_LEN     = 64,
   parameter int          D_WIDTH   = 640,
   parameter int          D_HEIGHT  = 480,
   parameter int          SPEED_MAX = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_ani_stb,
   input  logic                   i_paused,
   input  logic                   i_animate,
   output logic [12*N_STREAKS-1:0] o_x1,
   output logic [12*N_STREAKS-1:0] o_x2,
   output logic [12*N_STREAKS-1:0] o_y1,
   output logic [12*N_STREAKS-1:0] o_y2,
   output logic [7:0]             o_speed,
   output logic [1:0]             o_state
);

   // usable span of respawn centres
   localparam int XR = D_WIDTH - 2 * H_SIZE;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEL  = 2'd1,
      CRUISE = 2'd2,
      DECEL  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  speed_q, speed_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [11:0] x_q [N_STREAKS];
   logic [11:0] x_d [N_STREAKS];
   logic [11:0] y_q [N_STREAKS];
   logic [11:0] y_d [N_STREAKS];

   logic       step;
   logic [7:0] speed_inc;
   logic [7:0] speed_dec;

   function automatic logic [11:0] x_init(input int i);
      return 12'(H_SIZE + ((i + 1) * XR) / (N_STREAKS + 1));
   endfunction

   function automatic logic [11:0] y_init(input int i);
      return 12'((i * D_HEIGHT) / N_STREAKS);
   endfunction

   // low 10 bits of v rotated left by s
   function automatic logic [9:0] rot_lo10(
      input logic [15:0] v,
      input int          s
   );
      logic [9:0] r;
      r = '0;
      for (int b = 0; b < 10; b++) begin
         r[b] = v[4'((b + 16 - (s % 16)) % 16)];
      end
      return r;
   endfunction

   assign step      = i_ani_stb & ~i_paused;
   assign speed_inc = speed_q + 8'd1;
   assign speed_dec = speed_q - 8'd1;

   // Galois LFSR free-runs every clock, independent of pause
   always_comb begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
      if (lfsr_q[0]) begin
         lfsr_d = lfsr_d ^ 16'hB400;
      end
   end

   // speed ramp FSM, advanced only on an unpaused frame strobe
   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      if (step) begin
         unique case (state_q)
            IDLE: begin
               if (i_animate) begin
                  speed_d = speed_inc;
                  if (speed_inc >= 8'(SPEED_MAX)) begin
                     state_d = CRUISE;
                  end else begin
                     state_d = ACCEL;
                  end
               end
            end
            ACCEL: begin
               if (!i_animate) begin
                  state_d = DECEL;
               end else begin
                  speed_d = speed_inc;
                  if (speed_inc >= 8'(SPEED_MAX)) begin
                     state_d = CRUISE;
                  end
               end
            end
            CRUISE: begin
               if (!i_animate) begin
                  speed_d = speed_dec;
                  if (speed_dec == 8'd0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = DECEL;
                  end
               end
            end
            DECEL: begin
               if (i_animate) begin
                  state_d = ACCEL;
               end else begin
                  speed_d = speed_dec;
                  if (speed_dec == 8'd0) begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // streak motion and respawn, using the registered speed and lfsr
   always_comb begin
      for (int i = 0; i < N_STREAKS; i++) begin
         logic [8:0]  v;
         logic [12:0] ny;
         logic [10:0] r;
         x_d[i] = x_q[i];
         y_d[i] = y_q[i];
         if (speed_q == 8'd0) begin
            v = 9'd0;
         end else begin
            v = {1'b0, speed_q} + 9'(i % 4);
         end
         ny = {1'b0, y_q[i]} + {4'b0, v};
         r  = {1'b0, rot_lo10(lfsr_q, 3 * i)};
         if (r >= 11'(XR)) begin
            r = r - 11'(XR);
         end
         if (step) begin
            if (ny >= 13'(D_HEIGHT)) begin
               y_d[i] = 12'd0;
               x_d[i] = 12'(H_SIZE) + {1'b0, r};
            end else begin
               y_d[i] = ny[11:0];
            end
         end
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         speed_q <= 8'd0;
         lfsr_q  <= LFSR_SEED;
         for (int i = 0; i < N_STREAKS; i++) begin
            x_q[i] <= x_init(i);
            y_q[i] <= y_init(i);
         end
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         lfsr_q  <= lfsr_d;
         for (int i = 0; i < N_STREAKS; i++) begin
            x_q[i] <= x_d[i];
            y_q[i] <= y_d[i];
         end
      end
   end

   for (genvar g = 0; g < N_STREAKS; g++) begin : g_out
      assign o_x1[12*g +: 12] = x_q[g] - 12'(H_SIZE);
      assign o_x2[12*g +: 12] = x_q[g] + 12'(H_SIZE);
      assign o_y1[12*g +: 12] = y_q[g];
      assign o_y2[12*g +: 12] = y_q[g] + 12'(S_LEN);
   end

   assign o_speed = speed_q;
   assign o_state = state_q;

endmodule

// File: tb/tb_lightspeed_field.sv
// tb_lightspeed_field: reference-model bench for lightspeed_field.
// Directed ramp/wrap/pause/reset scenarios followed by random stimulus.
module tb_lightspeed_field;

   localparam int N    = 4;
   localparam int H    = 2;
   localparam int SL   = 64;
   localparam int DW   = 640;
   localparam int DH   = 480;
   localparam int SMAX = 8;
   localparam int XR   = DW - 2 * H;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_ani_stb = 1'b0;
   logic          i_paused = 1'b0;
   logic          i_animate = 1'b0;
   logic [12*N-1:0] o_x1, o_x2, o_y1, o_y2;
   logic [7:0]    o_speed;
   logic [1:0]    o_state;

   lightspeed_field dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_ani_stb (i_ani_stb),
      .i_paused  (i_paused),
      .i_animate (i_animate),
      .o_x1      (o_x1),
      .o_x2      (o_x2),
      .o_y1      (o_y1),
      .o_y2      (o_y2),
      .o_speed   (o_speed),
      .o_state   (o_state)
   );

   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model
   int          m_x [N];
   int          m_y [N];
   int          m_speed = 0;
   int          m_state = 0;
   logic [15:0] m_lfsr = 16'h0;
   bit          m_valid = 0;

   function automatic logic [15:0] galois(input logic [15:0] l);
      if (l[0]) return (l >> 1) ^ 16'hB400;
      return l >> 1;
   endfunction

   function automatic int rotl(input logic [15:0] l, input int s);
      int vv, sh;
      vv = int'(l);
      sh = s % 16;
      return ((vv << sh) | (vv >> (16 - sh))) & 32'hFFFF;
   endfunction

   always @(posedge i_clk) begin
      int sp, st, v, ny, r;
      if (i_rst) begin
         for (int i = 0; i < N; i++) begin
            m_x[i] <= H + ((i + 1) * XR) / (N + 1);
            m_y[i] <= (i * DH) / N;
         end
         m_speed <= 0;
         m_state <= 0;
         m_lfsr  <= SEED;
         m_valid <= 1;
      end else begin
         if (i_ani_stb && !i_paused) begin
            for (int i = 0; i < N; i++) begin
               v  = (m_speed == 0) ? 0 : m_speed + (i % 4);
               ny = m_y[i] + v;
               if (ny >= DH) begin
                  r = rotl(m_lfsr, 3 * i) % 1024;
                  if (r >= XR) r = r - XR;
                  m_y[i] <= 0;
                  m_x[i] <= H + r;
               end else begin
                  m_y[i] <= ny;
               end
            end
            sp = m_speed;
            st = m_state;
            case (m_state)
               0: if (i_animate) begin
                  sp = 1;
                  st = (sp >= SMAX) ? 2 : 1;
               end
               1: if (!i_animate) st = 3;
                  else begin
                     sp = sp + 1;
                     if (sp == SMAX) st = 2;
                  end
               2: if (!i_animate) begin
                  sp = sp - 1;
                  st = (sp == 0) ? 0 : 3;
               end
               default: if (i_animate) st = 1;
                  else begin
                     sp = sp - 1;
                     if (sp == 0) st = 0;
                  end
            endcase
            m_speed <= sp;
            m_state <= st;
         end
         m_lfsr <= galois(m_lfsr);
      end
   end

   // every-cycle comparison against the model
   always @(negedge i_clk) begin
      if (m_valid) begin
         for (int i = 0; i < N; i++) begin
            chk($sformatf("x1[%0d]", i), int'(o_x1[12*i +: 12]), (m_x[i] - H) & 4095);
            chk($sformatf("x2[%0d]", i), int'(o_x2[12*i +: 12]), (m_x[i] + H) & 4095);
            chk($sformatf("y1[%0d]", i), int'(o_y1[12*i +: 12]), m_y[i] & 4095);
            chk($sformatf("y2[%0d]", i), int'(o_y2[12*i +: 12]), (m_y[i] + SL) & 4095);
         end
         chk("speed", int'(o_speed), m_speed);
         chk("state", int'(o_state), m_state);
      end
   end

   function automatic int fx1(input int i);
      return int'(o_x1[12*i +: 12]);
   endfunction

   function automatic int fy1(input int i);
      return int'(o_y1[12*i +: 12]);
   endfunction

   task automatic cyc(input bit stb);
      i_ani_stb = stb;
      @(posedge i_clk);
      #2;
      i_ani_stb = 1'b0;
   endtask

   task automatic frame();
      repeat (9) cyc(1'b0);
      cyc(1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x1_0"}, fx1(0), 127);
      chk({tag, "_x2_0"}, int'(o_x2[11:0]), 131);
      chk({tag, "_y1_0"}, fy1(0), 0);
      chk({tag, "_y2_0"}, int'(o_y2[11:0]), 64);
      chk({tag, "_y1_1"}, fy1(1), 120);
      chk({tag, "_x1_3"}, fx1(3), 508);
      chk({tag, "_speed"}, int'(o_speed), 0);
      chk({tag, "_state"}, int'(o_state), 0);
   endtask

   int exp_y0 [8] = '{0, 1, 3, 6, 10, 15, 21, 28};

   initial begin
      int prev_y1, xc;
      bit found;

      // 1: reset and idle
      i_rst = 1'b1;
      repeat (3) cyc(1'b0);
      i_rst = 1'b0;
      chk_reset_vals("t1_rst");
      repeat (10) frame();
      chk_reset_vals("t1_idle");

      // 2: ramp up
      i_animate = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         frame();
         chk($sformatf("t2_speed%0d", k), int'(o_speed), k);
         chk($sformatf("t2_y0_%0d", k), fy1(0), exp_y0[k-1]);
         chk($sformatf("t2_state%0d", k), int'(o_state), (k == 8) ? 2 : 1);
      end

      // 3: cruise then ramp down, then reversal mid-decel
      repeat (5) frame();
      chk("t3_cruise", int'(o_state), 2);
      i_animate = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         frame();
         chk($sformatf("t3_speed%0d", k), int'(o_speed), k);
      end
      chk("t3_idle", int'(o_state), 0);
      i_animate = 1'b1;
      repeat (8) frame();
      chk("t3_cruise2", int'(o_state), 2);
      i_animate = 1'b0;
      repeat (4) frame();
      chk("t3_dec_speed", int'(o_speed), 4);
      chk("t3_dec_state", int'(o_state), 3);
      i_animate = 1'b1;
      frame();
      chk("t3_rev_state", int'(o_state), 1);
      chk("t3_rev_speed", int'(o_speed), 4);
      frame();
      chk("t3_rev_speed5", int'(o_speed), 5);
      repeat (3) frame();
      chk("t3_back_cruise", int'(o_state), 2);

      // 4: cruise until streak 1 wraps
      found = 0;
      for (int f = 0; f < 200 && !found; f++) begin
         prev_y1 = m_y[1];
         frame();
         if (m_y[1] < prev_y1) begin
            found = 1;
            chk("t4_y1_wrap", fy1(1), 0);
            xc = fx1(1) + H;
            chk("t4_x_range", int'(xc >= H && xc <= DW - H - 1), 1);
         end
      end
      chk("t4_wrap_seen", int'(found), 1);

      // 5: pause mid-accel
      i_animate = 1'b0;
      for (int f = 0; f < 20 && m_state != 0; f++) frame();
      chk("t5_idle", int'(o_state), 0);
      i_animate = 1'b1;
      repeat (3) frame();
      chk("t5_speed3", int'(o_speed), 3);
      i_paused = 1'b1;
      repeat (50) frame();
      chk("t5_frozen_speed", int'(o_speed), 3);
      chk("t5_frozen_state", int'(o_state), 1);
      i_paused = 1'b0;
      frame();
      chk("t5_resume", int'(o_speed), 4);

      // 6: reset coincident with a strobe during cruise
      repeat (4) frame();
      chk("t6_cruise", int'(o_state), 2);
      chk("t6_speed8", int'(o_speed), 8);
      repeat (3) cyc(1'b0);
      i_rst = 1'b1;
      cyc(1'b1);
      i_rst = 1'b0;
      chk_reset_vals("t6");

      // random stimulus against the model
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) i_animate = ~i_animate;
         i_paused = ($urandom_range(0, 7) == 0);
         i_rst    = ($urandom_range(0, 599) == 0);
         cyc($urandom_range(0, 2) == 0);
         i_rst = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
